// File: rtl/single_pc_fetch.sv
// PC register and instruction-fetch controller: issues req/ack fetches at the PC and
// presents each fetched word to decode through a one-entry valid/ready buffer.
module single_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_pc,
    input  logic [31:0] i_pc_next_seq,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; redirect outranks ack and ready everywhere except IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (i_redirect) begin
                    state_d = i_imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (i_imem_ack) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FULL: begin
                if (i_redirect || i_inst_ready) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_FULL;
                end
            end
            ST_DRAIN: begin
                if (i_imem_ack) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next values: PC, fetch request/address and the instruction buffer
    always_comb begin
        pc_d      = pc_q;
        addr_d    = addr_q;
        req_d     = req_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        case (state_q)
            ST_IDLE: begin
                req_d  = 1'b1;
                addr_d = pc_q;
            end
            ST_FETCH: begin
                if (i_redirect) begin
                    pc_d    = i_redirect_pc;
                    valid_d = 1'b0;
                    // Without an ack the outstanding request must stay on the bus untouched
                    if (i_imem_ack) begin
                        addr_d = i_redirect_pc;
                    end else begin
                        addr_d = addr_q;
                    end
                end else if (i_imem_ack) begin
                    inst_d    = i_imem_data;
                    inst_pc_d = addr_q;
                    valid_d   = 1'b1;
                    pc_d      = i_pc_next_seq;
                    req_d     = 1'b0;
                end else begin
                    req_d = req_q;
                end
            end
            ST_FULL: begin
                if (i_redirect) begin
                    pc_d    = i_redirect_pc;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    addr_d  = i_redirect_pc;
                end else if (i_inst_ready) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end else begin
                    valid_d = valid_q;
                end
            end
            ST_DRAIN: begin
                if (i_redirect) begin
                    pc_d = i_redirect_pc;
                end else begin
                    pc_d = pc_q;
                end
                // Stale data is dropped; re-issue at the most recent target
                if (i_imem_ack) begin
                    req_d  = 1'b1;
                    addr_d = i_redirect ? i_redirect_pc : pc_q;
                end else begin
                    req_d = req_q;
                end
            end
            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc_q      <= RESET_PC;
            addr_q    <= RESET_PC;
            req_q     <= 1'b0;
            inst_q    <= 32'h0000_0000;
            inst_pc_q <= 32'h0000_0000;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
        end
    end

    assign o_pc         = pc_q;
    assign o_imem_addr  = addr_q;
    assign o_imem_req   = req_q;
    assign o_inst       = inst_q;
    assign o_inst_pc    = inst_pc_q;
    assign o_inst_valid = valid_q;

endmodule

// File: tb/tb_single_pc_fetch.sv
// Bench for single_pc_fetch: directed scenarios against fixed expectations, then random
// traffic against a transaction-level model of the fetch unit.
module tb_single_pc_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] o_pc;
    logic [31:0] i_pc_next_seq;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0000_0000;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_data;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_valid;
    logic        i_inst_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    // Model: current pc, bus request, buffer contents, and whether the outstanding fetch is stale
    logic [31:0] m_pc, m_addr, m_inst, m_inst_pc;
    logic        m_req, m_valid, m_stale, m_warm;

    single_pc_fetch dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .o_pc         (o_pc),
        .i_pc_next_seq(i_pc_next_seq),
        .i_redirect   (i_redirect),
        .i_redirect_pc(i_redirect_pc),
        .o_imem_req   (o_imem_req),
        .o_imem_addr  (o_imem_addr),
        .i_imem_ack   (i_imem_ack),
        .i_imem_data  (i_imem_data),
        .o_inst       (o_inst),
        .o_inst_pc    (o_inst_pc),
        .o_inst_valid (o_inst_valid),
        .i_inst_ready (i_inst_ready)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    assign i_pc_next_seq = o_pc + 32'd1;
    assign i_imem_data   = memf(o_imem_addr);

    task automatic model_update(input logic red, input logic [31:0] rpc, input logic ack,
                                input logic rdy);
        if (!i_rst_n) begin
            m_pc = 32'h0; m_addr = 32'h0; m_inst = 32'h0; m_inst_pc = 32'h0;
            m_req = 1'b0; m_valid = 1'b0; m_stale = 1'b0; m_warm = 1'b1;
        end else if (m_warm) begin
            m_warm = 1'b0;
            m_req  = 1'b1;
            m_addr = m_pc;
        end else if (m_req) begin
            if (red) begin
                m_pc    = rpc;
                m_valid = 1'b0;
            end
            if (ack) begin
                if (m_stale || red) begin
                    m_addr  = m_pc;
                    m_stale = 1'b0;
                end else begin
                    m_inst    = memf(m_addr);
                    m_inst_pc = m_addr;
                    m_valid   = 1'b1;
                    m_pc      = m_pc + 32'd1;
                    m_req     = 1'b0;
                end
            end else if (red) begin
                m_stale = 1'b1;
            end
        end else begin
            if (red) begin
                m_pc = rpc; m_valid = 1'b0; m_req = 1'b1; m_addr = rpc;
            end else if (rdy) begin
                m_valid = 1'b0; m_req = 1'b1; m_addr = m_pc;
            end
        end
    endtask

    task automatic step(input logic red, input logic [31:0] rpc, input logic ack,
                        input logic rdy);
        i_redirect    = red;
        i_redirect_pc = rpc;
        i_imem_ack    = ack;
        i_inst_ready  = rdy;
        @(posedge i_clk);
        model_update(red, rpc, ack, rdy);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        for (int k = 0; k < 3; k++) step(1'b1, 32'h55, 1'b1, 1'b1);
        checks += 6;
        if (o_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", o_pc); end
        if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", o_imem_addr); end
        if (o_imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", o_imem_req); end
        if (o_inst !== 32'h0) begin errors++; $display("FAIL rst_inst: got %h want 0", o_inst); end
        if (o_inst_pc !== 32'h0) begin errors++; $display("FAIL rst_inst_pc: got %h want 0", o_inst_pc); end
        if (o_inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_inst_valid); end
    endtask

    task automatic test_sequential();
        i_rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        checks += 3;
        if (o_imem_req !== 1'b1) begin errors++; $display("FAIL seq_first_req: got %b want 1", o_imem_req); end
        if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL seq_first_addr: got %h want 0", o_imem_addr); end
        if (o_inst_valid !== 1'b0) begin errors++; $display("FAIL seq_first_valid: got %b want 0", o_inst_valid); end
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 32'h0, 1'b1, 1'b1);
            checks++;
            if (o_inst_valid !== ((k % 2) == 0)) begin
                errors++; $display("FAIL seq_valid[%0d]: got %b want %b", k, o_inst_valid, (k % 2) == 0);
            end
            if ((k % 2) == 0) begin
                checks += 2;
                if (o_inst_pc !== 32'(k / 2)) begin
                    errors++; $display("FAIL seq_inst_pc[%0d]: got %h want %h", k, o_inst_pc, k / 2);
                end
                if (o_inst !== memf(32'(k / 2))) begin
                    errors++; $display("FAIL seq_inst[%0d]: got %h want %h", k, o_inst, memf(32'(k / 2)));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 32'h0, k[0], 1'b0);
            checks++;
            if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h3 || o_inst !== memf(32'h3) ||
                o_imem_req !== 1'b0 || o_pc !== 32'h4) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b ipc=%h inst=%h req=%b pc=%h want v=1 ipc=3 inst=%h req=0 pc=4",
                         k, o_inst_valid, o_inst_pc, o_inst, o_imem_req, o_pc, memf(32'h3));
            end
        end
    endtask

    task automatic test_redirect_full();
        step(1'b1, 32'h40, 1'b0, 1'b1);
        checks++;
        if (o_inst_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h40 || o_pc !== 32'h40) begin
            errors++;
            $display("FAIL rf_issue: got v=%b req=%b addr=%h pc=%h want v=0 req=1 addr=40 pc=40",
                     o_inst_valid, o_imem_req, o_imem_addr, o_pc);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h40 || o_pc !== 32'h41) begin
            errors++;
            $display("FAIL rf_deliver: got v=%b ipc=%h pc=%h want v=1 ipc=40 pc=41", o_inst_valid, o_inst_pc, o_pc);
        end
    endtask

    task automatic test_drain();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h80, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h41 || o_inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL dr_hold[%0d]: got req=%b addr=%h v=%b want req=1 addr=41 v=0",
                         k, o_imem_req, o_imem_addr, o_inst_valid);
            end
            if (k < 2) step(1'b0, 32'h0, 1'b0, 1'b0);
        end
        step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (o_inst_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h80) begin
            errors++;
            $display("FAIL dr_reissue: got v=%b req=%b addr=%h want v=0 req=1 addr=80",
                     o_inst_valid, o_imem_req, o_imem_addr);
        end
        step(1'b1, 32'h80, 1'b0, 1'b0);
        step(1'b1, 32'hC0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (o_inst_valid !== 1'b0 || o_imem_addr !== 32'hC0 || o_pc !== 32'hC0) begin
            errors++;
            $display("FAIL dr_latest: got v=%b addr=%h pc=%h want v=0 addr=c0 pc=c0", o_inst_valid, o_imem_addr, o_pc);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'hC0) begin
            errors++; $display("FAIL dr_deliver: got v=%b ipc=%h want v=1 ipc=c0", o_inst_valid, o_inst_pc);
        end
    endtask

    task automatic test_redirect_ack();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b1, 32'h100, 1'b1, 1'b0);
        checks++;
        if (o_inst_valid !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h100 || o_pc !== 32'h100) begin
            errors++;
            $display("FAIL ra_drop: got v=%b req=%b addr=%h pc=%h want v=0 req=1 addr=100 pc=100",
                     o_inst_valid, o_imem_req, o_imem_addr, o_pc);
        end
        step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (o_inst_valid !== 1'b1 || o_inst_pc !== 32'h100) begin
            errors++; $display("FAIL ra_deliver: got v=%b ipc=%h want v=1 ipc=100", o_inst_valid, o_inst_pc);
        end
    endtask

    task automatic test_wrap();
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (o_inst_pc !== 32'hFFFF_FFFF || o_pc !== 32'h0 || o_inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_top: got ipc=%h pc=%h v=%b want ipc=ffffffff pc=0 v=1", o_inst_pc, o_pc, o_inst_valid);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (o_inst_pc !== 32'h0 || o_inst_valid !== 1'b1 || o_inst !== memf(32'h0)) begin
            errors++; $display("FAIL wrap_zero: got ipc=%h v=%b want ipc=0 v=1", o_inst_pc, o_inst_valid);
        end
    endtask

    task automatic test_reset_midfetch();
        step(1'b0, 32'h0, 1'b0, 1'b1);
        i_rst_n = 1'b0;
        step(1'b0, 32'h0, 1'b1, 1'b1);
        checks++;
        if (o_pc !== 32'h0 || o_imem_addr !== 32'h0 || o_imem_req !== 1'b0 || o_inst !== 32'h0 ||
            o_inst_pc !== 32'h0 || o_inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rm_reset: got pc=%h addr=%h req=%b inst=%h ipc=%h v=%b want all zero",
                     o_pc, o_imem_addr, o_imem_req, o_inst, o_inst_pc, o_inst_valid);
        end
        i_rst_n = 1'b1;
        step(1'b1, 32'h50, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        checks++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0 || o_inst_valid !== 1'b0 || o_pc !== 32'h0) begin
            errors++;
            $display("FAIL rm_stray: got req=%b addr=%h v=%b pc=%h want req=1 addr=0 v=0 pc=0",
                     o_imem_req, o_imem_addr, o_inst_valid, o_pc);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            i_rst_n = ($urandom_range(79) != 0);
            step($urandom_range(7) == 0, ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom,
                 $urandom_range(1) == 1, $urandom_range(1) == 1);
            checks++;
            if (o_pc !== m_pc || o_imem_addr !== m_addr || o_imem_req !== m_req ||
                o_inst_valid !== m_valid || o_inst_pc !== m_inst_pc || o_inst !== m_inst) begin
                errors++;
                $display("FAIL rand[%0d]: got pc=%h addr=%h req=%b v=%b ipc=%h inst=%h want pc=%h addr=%h req=%b v=%b ipc=%h inst=%h",
                         k, o_pc, o_imem_addr, o_imem_req, o_inst_valid, o_inst_pc, o_inst,
                         m_pc, m_addr, m_req, m_valid, m_inst_pc, m_inst);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_full();
        test_drain();
        test_redirect_ack();
        test_wrap();
        test_reset_midfetch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/single_pc_fetch.md
# single_pc_fetch

PC register and instruction-fetch controller for the single-cycle CPU datapath. It holds the current word-addressed PC and drives it to the sequential-PC incrementer. It takes the incremented value back as the default next PC, and it issues req/ack fetches to instruction memory. Fetched instructions are presented to decode through a one-entry valid/ready buffer, and execute can redirect the PC (branch taken / jump) at any time.

## Interface
- RESET_PC, 32'h0000_0000, word address loaded into the PC on reset
- i_clk  in  1  clock, all state updates on rising edge
- i_rst_n  in  1  synchronous, active-low reset
- o_pc  out  32  current PC register; feeds the incrementer input
- i_pc_next_seq  in  32  incrementer output (o_pc + 1, word address)
- i_redirect  in  1  branch-taken/jump strobe from execute
- i_redirect_pc  in  32  redirect target (word address)
- o_imem_req  out  1  fetch request, registered
- o_imem_addr  out  32  fetch address, registered, stable while o_imem_req=1
- i_imem_ack  in  1  memory ack; data valid in same cycle
- i_imem_data  in  32  instruction word
- o_inst  out  32  buffered instruction
- o_inst_pc  out  32  PC of buffered instruction
- o_inst_valid  out  1  buffer holds a live instruction
- i_inst_ready  in  1  decode consumes o_inst when valid&ready

## Operation
- States: IDLE, FETCH, FULL, DRAIN. Reset state IDLE.
- IDLE: one cycle after reset release. Next state FETCH: o_imem_req<=1, o_imem_addr<=pc.
- FETCH (req=1): on ack without redirect:
  - o_inst<=i_imem_data, o_inst_pc<=o_imem_addr, o_inst_valid<=1
  - pc<=i_pc_next_seq, req<=0, next state FULL.
- FULL (valid=1, req=0):
  - i_inst_ready=1: valid<=0, req<=1, o_imem_addr<=pc, next state FETCH.
  - i_inst_ready=0: hold everything.
- Redirect (i_redirect=1) has priority over ack and ready, in every state except IDLE:
  - pc<=i_redirect_pc, o_inst_valid<=0.
  - In FETCH with ack the same cycle: fetched data discarded, req<=1, o_imem_addr<=i_redirect_pc, stay FETCH.
  - In FETCH without ack: request must not be withdrawn. Next state DRAIN; req and o_imem_addr unchanged.
  - In FULL: buffered instruction dropped, req<=1, o_imem_addr<=i_redirect_pc, next state FETCH.
  - In DRAIN: pc<=i_redirect_pc (latest wins), stay DRAIN.
- DRAIN: on ack the data is discarded, req<=1, o_imem_addr<=pc (or i_redirect_pc if redirect the same cycle), next state FETCH.
- Redirect in IDLE is ignored.
- Arithmetic: block never adds. Next sequential PC is i_pc_next_seq verbatim, so 32'hFFFF_FFFF wraps to 0 via the incrementer.
- i_imem_ack while req=0 (IDLE, FULL) is ignored.

## Timing
- Reset (i_rst_n=0 at edge), every output:
  - o_pc=RESET_PC, o_imem_addr=RESET_PC
  - o_imem_req=0, o_inst=0, o_inst_pc=0, o_inst_valid=0
- Reset mid-fetch aborts the request. An ack arriving during or after reset, before the new req, is ignored.
- First req asserted in the 2nd cycle after reset release.
- Ack to o_inst_valid: 1 cycle. Consume (valid&ready) to next req: 1 cycle. Peak throughput: 1 instruction per 2 cycles with zero-wait memory.
- Redirect to first req at the target address:
  - 1 cycle from FETCH+ack or FULL.
  - From DRAIN, 1 cycle after the drained ack.
- o_pc updates the cycle after ack or redirect. i_pc_next_seq must be valid combinationally from o_pc.

## Test plan
- Reset, RESET_PC=0, zero-wait ack, ready=1 -> o_inst_pc sequence 0,1,2,3; valid high every other cycle; req first high 2 cycles after i_rst_n rises.
- Backpressure: ready=0 for 5 cycles while FULL -> o_inst/o_inst_pc/valid stable, req=0, o_pc already advanced by 1.
- Redirect in FULL to 32'h40 -> valid drops next cycle, next req addr 32'h40, next delivered o_inst_pc=32'h40.
- Redirect to 32'h80 while req outstanding, ack 3 cycles later -> addr held until ack, data discarded (no valid), then req at 32'h80. A second redirect to 32'hC0 during DRAIN -> req at 32'hC0 instead.
- Redirect and ack in the same FETCH cycle -> data dropped, next req at redirect target.
- Wrap: pc=32'hFFFF_FFFF, incrementer returns 0 -> o_inst_pc=32'hFFFF_FFFF then 0. Reset asserted with req pending -> all outputs at reset values, stray ack ignored.
